// File: rtl/vga_tile_raster.sv
// Parametrised VGA raster: sync timing plus a per-tile colour fetch from an external palette RAM.
// Optional feature macro: VGA_BORDER_EN forces the outermost active-area pixels to full white.
module vga_tile_raster #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_PULSE   = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_PULSE   = 2,
    parameter int V_BP      = 33,
    parameter int TILE_W    = 40,
    parameter int TILE_H    = 40,
    parameter int COLS      = 16,
    parameter int ROWS      = 12,
    parameter int CW        = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 10,
    parameter int AW        = $clog2(COLS * ROWS)
) (
    input  logic              vgaclk,
    input  logic              rst,
    output logic [AW-1:0]     tile_addr,
    input  logic [3*CW-1:0]   tile_color,
    output logic [CNT_W-1:0]  hc,
    output logic [CNT_W-1:0]  vc,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int SX_W    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int SY_W    = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_PULSE);
    localparam logic [COL_W-1:0] COL_LIM  = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(ROWS);
    localparam logic [SX_W-1:0]  SX_LAST  = SX_W'(TILE_W - 1);
    localparam logic [SY_W-1:0]  SY_LAST  = SY_W'(TILE_H - 1);

    if (COLS * TILE_W > H_ACTIVE || ROWS * TILE_H > V_ACTIVE) begin : g_grid_check
        $error("vga_tile_raster: tile grid does not fit inside the active area");
    end

    // ---------------- stage 0: counters and palette address ----------------
    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [SX_W-1:0]  subx_q, subx_d;
    logic [SY_W-1:0]  suby_q, suby_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap = (hc_q == H_LAST);
        v_wrap = (vc_q == V_LAST);
        hc_d   = h_wrap ? '0 : hc_q + 1'b1;
        vc_d   = vc_q;
        col_d  = col_q;
        subx_d = subx_q;
        row_d  = row_q;
        suby_d = suby_q;

        // Column tracking saturates at COLS so the right margin reads as out-of-grid.
        if (h_wrap) begin
            col_d  = '0;
            subx_d = '0;
        end else if (subx_q == SX_LAST) begin
            subx_d = '0;
            if (col_q != COL_LIM) col_d = col_q + 1'b1;
        end else begin
            subx_d = subx_q + 1'b1;
        end

        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + 1'b1;
            if (v_wrap) begin
                row_d  = '0;
                suby_d = '0;
            end else if (suby_q == SY_LAST) begin
                suby_d = '0;
                if (row_q != ROW_LIM) row_d = row_q + 1'b1;
            end else begin
                suby_d = suby_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            col_q  <= '0;
            subx_q <= '0;
            row_q  <= '0;
            suby_q <= '0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            col_q  <= col_d;
            subx_q <= subx_d;
            row_q  <= row_d;
            suby_q <= suby_d;
        end
    end

    logic hs0, vs0, act0, grid0, fs0;
    assign hs0   = (hc_q >= H_SYNC_S) && (hc_q < H_SYNC_E);
    assign vs0   = (vc_q >= V_SYNC_S) && (vc_q < V_SYNC_E);
    assign act0  = (hc_q < H_ACT) && (vc_q < V_ACT);
    assign grid0 = (col_q < COL_LIM) && (row_q < ROW_LIM);
    assign fs0   = (hc_q == '0) && (vc_q == '0);

    assign tile_addr = grid0 ? AW'(int'(row_q) * COLS + int'(col_q)) : '0;

    // ---------------- stage 1: palette data arrives, flags delayed ----------------
    logic hs1_q, vs1_q, act1_q, pix1_q, fs1_q;
`ifdef VGA_BORDER_EN
    logic border0, border1_q;
    assign border0 = act0 && ((hc_q == '0) || (hc_q == H_ACT - 1'b1) ||
                              (vc_q == '0) || (vc_q == V_ACT - 1'b1));
    always_ff @(posedge vgaclk) begin
        if (!rst) border1_q <= 1'b0;
        else      border1_q <= border0;
    end
`endif

    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            act1_q <= 1'b0;
            pix1_q <= 1'b0;
            fs1_q  <= 1'b0;
        end else begin
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            act1_q <= act0;
            pix1_q <= act0 && grid0;
            fs1_q  <= fs0;
        end
    end

    // ---------------- stage 2: registered pin outputs ----------------
    logic [3*CW-1:0] rgb_d, rgb_q;
    logic            hsync_q, vsync_q, active_q, frame_start_q;

    always_comb begin
        rgb_d = pix1_q ? tile_color : '0;
`ifdef VGA_BORDER_EN
        if (border1_q) rgb_d = '1;
`endif
    end

    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            hsync_q       <= hs1_q ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= vs1_q ? VSYNC_POL : ~VSYNC_POL;
            active_q      <= act1_q;
            frame_start_q <= fs1_q;
            rgb_q         <= rgb_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign red         = rgb_q[3*CW-1:2*CW];
    assign green       = rgb_q[2*CW-1:CW];
    assign blue        = rgb_q[CW-1:0];

endmodule
